score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/game_pkg.sv | 28 ++
 rtl/frame_timer.sv | 33 +++
 rtl/score_keeper.sv | 137 +++++++++++++
 tb/tb_score_keeper.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the tank-game score keeper.
// Lives the bonus helper here so any block that grants a life saturates identically.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PLAY        = 2'd1,
        S_LEVEL_CLEAR = 2'd2,
        S_GAME_OVER   = 2'd3
    } state_e;

    localparam int TANKS_PER_LEVEL_DEF   = 20;
    localparam int LIVES_INIT_DEF        = 3;
    localparam int LIVES_MAX_DEF         = 6;
    localparam int MAX_LEVEL_DEF         = 9;
    localparam int INTERLEVEL_FRAMES_DEF = 120;

    // A player already out of the game earns nothing; others gain one life up to the cap.
    function automatic logic [3:0] life_bonus(input logic [3:0] lives, input logic [3:0] cap);
        if (lives == 4'd0)
            return 4'd0;
        else if (lives >= cap)
            return cap;
        else
            return lives + 4'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-level pause countdown: load sets the frame count, each tick counts down,
// done flags the tick that brings the count to zero.
module frame_timer #(
    parameter int FRAMES = 120
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic tick_i,
    output logic done_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_o = 1'b0;
        if (load_i) begin
            cnt_d = 8'(FRAMES);
        end else if (tick_i && cnt_q != 8'd0) begin
            cnt_d  = cnt_q - 8'd1;
            done_o = (cnt_q == 8'd1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/score_keeper.sv
// Game progress tracker: enemies remaining, level, per-player lives and the
// IDLE/PLAY/LEVEL_CLEAR/GAME_OVER flow. All outputs come straight from flops.
module score_keeper
    import game_pkg::*;
#(
    parameter int TANKS_PER_LEVEL   = TANKS_PER_LEVEL_DEF,
    parameter int LIVES_INIT        = LIVES_INIT_DEF,
    parameter int LIVES_MAX         = LIVES_MAX_DEF,
    parameter int MAX_LEVEL         = MAX_LEVEL_DEF,
    parameter int INTERLEVEL_FRAMES = INTERLEVEL_FRAMES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       two_player_i,
    input  logic       frame_tick_i,
    input  logic       enemy_killed_i,
    input  logic       player_1_hit_i,
    input  logic       player_2_hit_i,
    output logic [5:0] tank_left_o,
    output logic [3:0] level_o,
    output logic [3:0] player_1_live_left_o,
    output logic [3:0] player_2_live_left_o,
    output logic [1:0] state_o,
    output logic       level_clear_o,
    output logic       game_over_o,
    output logic       game_won_o
);

    state_e     state_q, state_d;
    logic [5:0] tank_q, tank_d, tank_n;
    logic [3:0] level_q, level_d;
    logic [3:0] p1_q, p1_d, p1_n;
    logic [3:0] p2_q, p2_d, p2_n;
    logic       won_q, won_d;
    logic       lc_q, go_q;
    logic       timer_load, timer_tick, timer_done;

    frame_timer #(.FRAMES(INTERLEVEL_FRAMES)) u_frame_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (timer_load),
        .tick_i (timer_tick),
        .done_o (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        tank_d     = tank_q;
        level_d    = level_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        won_d      = won_q;
        timer_load = 1'b0;
        timer_tick = 1'b0;
        tank_n     = tank_q;
        p1_n       = p1_q;
        p2_n       = p2_q;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_i) begin
                    tank_d  = 6'(TANKS_PER_LEVEL);
                    level_d = 4'd1;
                    p1_d    = 4'(LIVES_INIT);
                    p2_d    = two_player_i ? 4'(LIVES_INIT) : 4'd0;
                    won_d   = 1'b0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (enemy_killed_i && tank_q != 6'd0) tank_n = tank_q - 6'd1;
                if (player_1_hit_i && p1_q != 4'd0)   p1_n   = p1_q - 4'd1;
                if (player_2_hit_i && p2_q != 4'd0)   p2_n   = p2_q - 4'd1;
                tank_d = tank_n;
                p1_d   = p1_n;
                p2_d   = p2_n;
                // Losing the last life beats clearing the level in the same cycle.
                if (p1_n == 4'd0 && p2_n == 4'd0) begin
                    state_d = S_GAME_OVER;
                    won_d   = 1'b0;
                end else if (tank_n == 6'd0) begin
                    state_d    = S_LEVEL_CLEAR;
                    timer_load = 1'b1;
                end
            end
            S_LEVEL_CLEAR: begin
                timer_tick = frame_tick_i;
                if (timer_done) begin
                    if (level_q == 4'(MAX_LEVEL)) begin
                        state_d = S_GAME_OVER;
                        won_d   = 1'b1;
                    end else begin
                        level_d = level_q + 4'd1;
                        tank_d  = 6'(TANKS_PER_LEVEL);
                        p1_d    = life_bonus(p1_q, 4'(LIVES_MAX));
                        p2_d    = life_bonus(p2_q, 4'(LIVES_MAX));
                        state_d = S_PLAY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tank_q  <= 6'd0;
            level_q <= 4'd0;
            p1_q    <= 4'd0;
            p2_q    <= 4'd0;
            won_q   <= 1'b0;
            lc_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tank_q  <= tank_d;
            level_q <= level_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            won_q   <= won_d;
            lc_q    <= (state_d == S_LEVEL_CLEAR);
            go_q    <= (state_d == S_GAME_OVER);
        end
    end

    assign tank_left_o          = tank_q;
    assign level_o              = level_q;
    assign player_1_live_left_o = p1_q;
    assign player_2_live_left_o = p2_q;
    assign state_o              = state_q;
    assign level_clear_o        = lc_q;
    assign game_over_o          = go_q;
    assign game_won_o           = won_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a plain-arithmetic game model predicts every
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       start_i, two_player_i, frame_tick_i, enemy_killed_i;
    logic       player_1_hit_i, player_2_hit_i;
    logic [5:0] tank_left_o;
    logic [3:0] level_o, player_1_live_left_o, player_2_live_left_o;
    logic [1:0] state_o;
    logic       level_clear_o, game_over_o, game_won_o;

    score_keeper dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .start_i              (start_i),
        .two_player_i         (two_player_i),
        .frame_tick_i         (frame_tick_i),
        .enemy_killed_i       (enemy_killed_i),
        .player_1_hit_i       (player_1_hit_i),
        .player_2_hit_i       (player_2_hit_i),
        .tank_left_o          (tank_left_o),
        .level_o              (level_o),
        .player_1_live_left_o (player_1_live_left_o),
        .player_2_live_left_o (player_2_live_left_o),
        .state_o              (state_o),
        .level_clear_o        (level_clear_o),
        .game_over_o          (game_over_o),
        .game_won_o           (game_won_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tank; int lvl; int p1; int p2; int st; int lc; int go; int won;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Game model: 0 idle, 1 playing, 2 pause between levels, 3 over.
    int m_st, m_tanks, m_lvl, m_p1, m_p2, m_frames, m_won;

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bonus(input int l);
        if (l == 0) return 0;
        return (l + 1 > 6) ? 6 : l + 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_tanks = 0; m_lvl = 0; m_p1 = 0; m_p2 = 0; m_frames = 0; m_won = 0;
    endtask

    task automatic model_cycle(input bit st, input bit tp, input bit ft, input bit ek,
                               input bit h1, input bit h2);
        if (m_st == 0 || m_st == 3) begin
            if (st) begin
                m_tanks = 20; m_lvl = 1; m_p1 = 3; m_p2 = tp ? 3 : 0; m_won = 0; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (ek && m_tanks > 0) m_tanks--;
            if (h1 && m_p1 > 0) m_p1--;
            if (h2 && m_p2 > 0) m_p2--;
            if (m_p1 == 0 && m_p2 == 0) begin
                m_st = 3; m_won = 0;
            end else if (m_tanks == 0) begin
                m_st = 2; m_frames = 120;
            end
        end else if (ft) begin
            m_frames--;
            if (m_frames == 0) begin
                if (m_lvl == 9) begin
                    m_st = 3; m_won = 1;
                end else begin
                    m_lvl++; m_tanks = 20; m_p1 = bonus(m_p1); m_p2 = bonus(m_p2); m_st = 1;
                end
            end
        end
    endtask

    task automatic step(input bit st, input bit tp, input bit ft, input bit ek,
                        input bit h1, input bit h2);
        exp_t e;
        @(negedge clk);
        start_i = st; two_player_i = tp; frame_tick_i = ft;
        enemy_killed_i = ek; player_1_hit_i = h1; player_2_hit_i = h2;
        model_cycle(st, tp, ft, ek, h1, h2);
        e.tank = m_tanks; e.lvl = m_lvl; e.p1 = m_p1; e.p2 = m_p2; e.st = m_st;
        e.lc = (m_st == 2); e.go = (m_st == 3); e.won = m_won;
        exp_q.push_back(e);
    endtask

    // Let the last issued cycle land and be checked, then idle the inputs.
    task automatic quiesce();
        @(posedge clk);
        #3;
        start_i = 0; two_player_i = 0; frame_tick_i = 0;
        enemy_killed_i = 0; player_1_hit_i = 0; player_2_hit_i = 0;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " tank_left"}, int'(tank_left_o), 0);
        cmp({tag, " level"}, int'(level_o), 0);
        cmp({tag, " p1_lives"}, int'(player_1_live_left_o), 0);
        cmp({tag, " p2_lives"}, int'(player_2_live_left_o), 0);
        cmp({tag, " state"}, int'(state_o), 0);
        cmp({tag, " level_clear"}, int'(level_clear_o), 0);
        cmp({tag, " game_over"}, int'(game_over_o), 0);
        cmp({tag, " game_won"}, int'(game_won_o), 0);
    endtask

    task automatic clear_level();
        repeat (20) step(0, 0, 0, 1, 0, 0);
        repeat (120) step(0, 0, 1, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a registered result for the queued stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                cmp("sb tank_left", int'(tank_left_o), e.tank);
                cmp("sb level", int'(level_o), e.lvl);
                cmp("sb p1_lives", int'(player_1_live_left_o), e.p1);
                cmp("sb p2_lives", int'(player_2_live_left_o), e.p2);
                cmp("sb state", int'(state_o), e.st);
                cmp("sb level_clear", int'(level_clear_o), e.lc);
                cmp("sb game_over", int'(game_over_o), e.go);
                cmp("sb game_won", int'(game_won_o), e.won);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 0;
        start_i = 0; two_player_i = 0; frame_tick_i = 0;
        enemy_killed_i = 0; player_1_hit_i = 0; player_2_hit_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_ni = 1;

        // Two-player start, then a full level clear with bonus lives.
        step(1, 1, 0, 0, 0, 0);
        quiesce();
        cmp("start tank_left", int'(tank_left_o), 20);
        cmp("start lives", int'({player_1_live_left_o, player_2_live_left_o}), 8'h33);
        repeat (20) step(0, 0, 0, 1, 0, 0);
        quiesce();
        cmp("cleared state", int'(state_o), 2);
        repeat (120) step(0, 0, 1, 0, 0, 0);
        quiesce();
        cmp("lvl2 level", int'(level_o), 2);
        cmp("lvl2 lives", int'({player_1_live_left_o, player_2_live_left_o}), 8'h44);

        // P2 drained to zero and beyond; it gets no bonus afterwards.
        repeat (6) step(0, 0, 0, 0, 0, 1);
        quiesce();
        cmp("p2 dead lives", int'(player_2_live_left_o), 0);
        cmp("p2 dead state", int'(state_o), 1);
        clear_level();
        quiesce();
        cmp("p2 no bonus", int'(player_2_live_left_o), 0);

        // Clear through the last level; P1 saturates at 6.
        for (int l = 3; l <= 9; l++) clear_level();
        quiesce();
        cmp("won state", int'(state_o), 3);
        cmp("won flag", int'(game_won_o), 1);
        cmp("won p1 cap", int'(player_1_live_left_o), 6);

        // Restart single player; last life lost on the same cycle as the last kill.
        step(1, 0, 0, 0, 0, 0);
        quiesce();
        cmp("restart level", int'(level_o), 1);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        repeat (19) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        quiesce();
        cmp("lose state", int'(state_o), 3);
        cmp("lose game_over", int'(game_over_o), 1);
        cmp("lose won", int'(game_won_o), 0);
        cmp("lose tank_left", int'(tank_left_o), 0);

        // Randomized play.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step(($urandom % 40) == 0, $urandom % 2, $urandom % 2,
                 ($urandom % 3) == 0, ($urandom % 12) == 0, ($urandom % 12) == 0);
        quiesce();

        // Mid-game reset abandons progress.
        rst_ni = 0;
        #1 check_zero("midgame reset");
        model_reset();
        @(negedge clk) rst_ni = 1;
        step(1, 1, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 1, 0, 0);
        repeat (70) step(0, 0, 1, 0, 0, 0);
        quiesce();
        cmp("pause state", int'(state_o), 2);

        // Reset during the pause takes effect with no clock edge.
        #1 rst_ni = 0;
        #1 check_zero("pause reset");
        model_reset();
        @(negedge clk) rst_ni = 1;
        step(1, 0, 0, 0, 0, 0);
        quiesce();
        cmp("post reset level", int'(level_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
